// File: rtl/nco_pkg.sv
// Shared types and phase-decode helpers for the NCO phase controller.
package nco_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int LUT_AW = 2;

    // Helpers take the top four phase bits: {quadrant[1:0], index[1:0]}.
    function automatic logic [1:0] quad_of(input logic [3:0] top4);
        return top4[3:2];
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] top4);
        return top4[1:0];
    endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// Phase accumulator with latched tuning word and quarter-wave address/sign decode.
module nco_phase_acc
    import nco_pkg::*;
#(
    parameter int PW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [PW-1:0]     ftw,
    output logic [LUT_AW-1:0] lut_addr,
    output logic              neg
);

    logic [PW-1:0]     phase_q;
    logic [PW-1:0]     phase_d;
    logic [PW-1:0]     ftw_q;
    logic [PW-1:0]     ftw_d;
    logic [3:0]        top4;
    logic [1:0]        quad;
    logic [LUT_AW-1:0] idx;

    always_comb begin
        phase_d = phase_q;
        ftw_d   = ftw_q;
        if (load) begin
            phase_d = '0;
            ftw_d   = ftw;
        end else if (step) begin
            phase_d = phase_q + ftw_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            ftw_q   <= '0;
        end else begin
            phase_q <= phase_d;
            ftw_q   <= ftw_d;
        end
    end

    assign top4 = phase_q[PW-1 -: 4];
    assign quad = quad_of(top4);
    assign idx  = idx_of(top4);
    assign neg  = quad[1];

    // Odd quadrants read the table backwards: invert every index bit.
    generate
        for (genvar gi = 0; gi < LUT_AW; gi++) begin : g_mirror
            assign lut_addr[gi] = idx[gi] ^ quad[0];
        end
    endgenerate

endmodule

// File: rtl/nco_phase_ctrl.sv
// NCO controller: start/stop FSM, LUT read issue and signed output stage with valid/ready.
module nco_phase_ctrl
    import nco_pkg::*;
#(
    parameter int PW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [PW-1:0]     ftw,
    output logic [LUT_AW-1:0] lut_addr,
    output logic              lut_en,
    input  logic [DW-1:0]     lut_data,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_t        state_q;
    state_t        state_d;
    logic          v1_q;
    logic          v1_d;
    logic          neg1_q;
    logic          neg1_d;
    logic          out_valid_q;
    logic          out_valid_d;
    logic [DW-1:0] out_data_q;
    logic [DW-1:0] out_data_d;
    logic          adv;
    logic          run;
    logic          load;
    logic          step;
    logic          neg;

    assign run  = (state_q == RUN);
    assign adv  = ~out_valid_q | out_ready;
    assign load = (state_q == IDLE) & start;
    assign step = run & adv;

    // Stop has priority; a start seen while running is dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (stop)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        v1_d        = v1_q;
        neg1_d      = neg1_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv) begin
            v1_d        = run;
            neg1_d      = neg;
            out_valid_d = v1_q;
            out_data_d  = neg1_q ? -lut_data : lut_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            v1_q        <= 1'b0;
            neg1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            v1_q        <= v1_d;
            neg1_q      <= neg1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    nco_phase_acc #(
        .PW(PW)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .ftw      (ftw),
        .lut_addr (lut_addr),
        .neg      (neg)
    );

    // The LUT stalls with the rest of the pipeline so its data lines up with v1.
    assign lut_en    = adv;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = run | v1_q | out_valid_q;

endmodule

// File: tb/tb_nco_phase_ctrl.sv
// Directed and randomized checks of nco_phase_ctrl against a phase-arithmetic sample model.
module tb_nco_phase_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] ftw = '0;
    logic [1:0]  lut_addr;
    logic        lut_en;
    logic [31:0] lut_data = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    logic [31:0] lut_tab [4];

    int          n_checks = 0;
    int          n_fail = 0;
    bit          running = 0;
    logic [31:0] ftw_lat = '0;
    int unsigned iss = 0;
    int unsigned acc = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    longint      got [$];
    longint      lit1 [16] = '{10, 20, 30, 40, 40, 30, 20, 10,
                               -10, -20, -30, -40, -40, -30, -20, -10};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lut_en) lut_data <= lut_tab[lut_addr];
    end

    nco_phase_ctrl #(.PW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .ftw       (ftw),
        .lut_addr  (lut_addr),
        .lut_en    (lut_en),
        .lut_data  (lut_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample k of a run sits at phase k*ftw; the top two bits pick the
    // quadrant, the next two the table slot, read backwards in odd quadrants.
    function automatic logic [31:0] phase_of(input int unsigned k, input logic [31:0] f);
        logic [31:0] p;
        p = k * f;
        return p;
    endfunction

    function automatic int exp_addr(input logic [31:0] p);
        int unsigned quad;
        int unsigned idx;
        quad = p / 32'h4000_0000;
        idx  = (p / 32'h1000_0000) % 4;
        return (quad % 2 == 1) ? int'(3 - idx) : int'(idx);
    endfunction

    function automatic longint exp_sample(input logic [31:0] p);
        longint mag;
        mag = longint'(lut_tab[exp_addr(p)]);
        return (p / 32'h4000_0000 >= 2) ? -mag : mag;
    endfunction

    task automatic step(input logic rdy, input logic st, input logic sp);
        @(negedge clk);
        out_ready = rdy;
        start     = st;
        stop      = sp;
        #1;
        chk("lut_en", longint'(lut_en), longint'(!out_valid || out_ready));
        chk("busy", longint'(busy), longint'(running || iss != acc));
        if (prev_stall) chk("stall_hold", longint'(out_data), longint'(prev_data));
        if (running && lut_en) begin
            chk("lut_addr", longint'(lut_addr), longint'(exp_addr(phase_of(iss, ftw_lat))));
            iss++;
        end
        if (out_valid && out_ready) begin
            chk("out_data", longint'($signed(out_data)), exp_sample(phase_of(acc, ftw_lat)));
            got.push_back(longint'($signed(out_data)));
            acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (!running && st) begin
            running = 1;
            ftw_lat = ftw;
            iss     = 0;
            acc     = 0;
            got.delete();
        end else if (running && sp) begin
            running = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        running    = 0;
        iss        = 0;
        acc        = 0;
        prev_stall = 0;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_lut_addr", longint'(lut_addr), 0);
        chk("rst_lut_en", longint'(lut_en), longint'(!out_valid || out_ready));
    endtask

    // mode 0: always ready; 1: five-cycle stall mid-stream; 2: random ready and ftw churn.
    task automatic run_stream(input logic [31:0] f, input int n, input int mode, input bit lit);
        int          first_valid;
        int unsigned acc_mark;
        int          guard;
        logic        rdy;
        ftw = f;
        first_valid = -1;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= n; i++) begin
            rdy = 1'b1;
            if (mode == 1 && i >= 10 && i < 15) rdy = 1'b0;
            if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
            step(rdy, 1'b0, 1'b0);
            if (first_valid < 0 && out_valid) first_valid = i;
            if (mode == 2) ftw = $urandom;
        end
        chk("first_valid_step", longint'(first_valid), 3);
        if (lit) begin
            chk("lit_count_ok", longint'(got.size() >= 16), 1);
            for (int i = 0; i < 16 && i < got.size(); i++) chk("lit_seq", got[i], lit1[i]);
        end
        step((mode == 2) ? logic'($urandom_range(0, 1)) : 1'b1, 1'b1, 1'b1);
        acc_mark = acc;
        guard = 0;
        while (busy && guard < 20) begin
            step(1'b1, 1'b0, 1'b0);
            guard++;
        end
        chk("drain_timeout", longint'(guard < 20), 1);
        chk("stop_extra_le2", longint'(acc - acc_mark <= 2), 1);
        chk("stop_all_drained", longint'(acc), longint'(iss));
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("idle_no_valid", longint'(out_valid), 0);
        end
    endtask

    initial begin
        lut_tab = '{32'd10, 32'd20, 32'd30, 32'd40};
        repeat (2) @(negedge clk);
        do_reset();

        run_stream(32'h1000_0000, 40, 0, 1);
        run_stream(32'h2000_0000, 20, 0, 0);
        run_stream(32'h1000_0000, 40, 1, 1);
        run_stream(32'h0000_0000, 20, 0, 0);
        run_stream(32'hF000_0000, 20, 0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) lut_tab[j] = $urandom & 32'h7FFF_FFFF;
            run_stream($urandom, 60, 2, 0);
        end

        lut_tab = '{32'd10, 32'd20, 32'd30, 32'd40};
        ftw = 32'h1000_0000;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pre_rst_stalled", longint'(out_valid && !out_ready), 1);
        do_reset();
        run_stream(32'h1000_0000, 40, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
